data_sync_mc: RTL and testbench

- Multi-channel successor to the single-bus data synchroniser. Brings NUM_CH independent, unsynchronised data buses into the CLK domain, each qualified by its own enable.
- Each enable is synchronised through a NUM_STAGES flop chain and edge-detected in level or toggle mode. The bus is captured into a per-channel holding register.
- Held words are merged round-robin onto one valid/ready output with a channel tag.
- Sits at the receive side of any multi-source crossing feeding a single consumer, such as a register file or FIFO.

---
 rtl/data_sync_mc.sv | 127 ++++++++++++
 tb/tb_data_sync_mc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified bus synchroniser: per-channel capture into holding
// registers, merged round-robin onto a single valid/ready output with a channel tag.
module data_sync_mc #(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TOGGLE_MODE = 0,
  parameter int unsigned CHW         = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH*DATA_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]            bus_enable,
  output logic [NUM_CH-1:0]            enable_pulse,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CHW-1:0]               out_chan,
  output logic [NUM_CH-1:0]            overrun,
  input  logic [NUM_CH-1:0]            overrun_clr
);

  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]     sync_q [NUM_STAGES];
  logic [NUM_CH-1:0]     sync_d [NUM_STAGES];
  logic [NUM_CH-1:0]     en_d_q, en_d_d;
  logic [DATA_WIDTH-1:0] hold_q [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_d [NUM_CH];
  logic [NUM_CH-1:0]     hold_full_q, hold_full_d;
  logic [NUM_CH-1:0]     pulse_q, pulse_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CHW-1:0]        out_chan_q, out_chan_d;
  logic [NUM_CH-1:0]     ovr_q, ovr_d;
  logic [IW-1:0]         ptr_q, ptr_d;

  logic [NUM_CH-1:0]     en_s_c, ev_c;
  logic                  load_c, take_c, gnt_found_c, granted_c;
  logic [IW-1:0]         gnt_idx_c, cand_c;

  always_comb begin
    for (int s = 0; s < NUM_STAGES; s++) sync_d[s] = (s == 0) ? bus_enable : sync_q[(s == 0) ? 0 : s - 1];
    en_s_c = sync_q[NUM_STAGES-1];
    en_d_d = en_s_c;
    ev_c   = (TOGGLE_MODE != 0) ? (en_s_c ^ en_d_q) : (en_s_c & ~en_d_q);

    // Round-robin search starting just after the last granted channel
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand_c = IW'((32'(ptr_q) + k) % NUM_CH);
      if (!gnt_found_c && hold_full_q[cand_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
    load_c = !out_valid_q || out_ready;
    take_c = load_c && gnt_found_c;

    hold_full_d = hold_full_q;
    pulse_d     = ev_c;
    ovr_d       = ovr_q & ~overrun_clr;
    granted_c   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      hold_d[i] = hold_q[i];
      granted_c = take_c && (gnt_idx_c == IW'(i));
      if (granted_c) hold_full_d[i] = 1'b0;
      // A word leaving this cycle frees the slot for a same-cycle capture
      if (ev_c[i]) begin
        if (!hold_full_q[i] || granted_c) begin
          hold_d[i]      = unsync_bus[i*DATA_WIDTH +: DATA_WIDTH];
          hold_full_d[i] = 1'b1;
        end else begin
          ovr_d[i] = 1'b1;
        end
      end
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load_c) begin
      out_valid_d = gnt_found_c;
      if (gnt_found_c) begin
        out_data_d = hold_q[gnt_idx_c];
        out_chan_d = CHW'(gnt_idx_c);
        ptr_d      = gnt_idx_c;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int s = 0; s < NUM_STAGES; s++) sync_q[s] <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
      en_d_q      <= '0;
      hold_full_q <= '0;
      pulse_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ovr_q       <= '0;
      ptr_q       <= IW'(NUM_CH - 1);
    end else begin
      for (int s = 0; s < NUM_STAGES; s++) sync_q[s] <= sync_d[s];
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= hold_d[i];
      en_d_q      <= en_d_d;
      hold_full_q <= hold_full_d;
      pulse_q     <= pulse_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ovr_q       <= ovr_d;
      ptr_q       <= ptr_d;
    end
  end

  assign enable_pulse = pulse_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_chan     = out_chan_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_data_sync_mc.sv
// Directed bench for data_sync_mc: level-mode instance plus a toggle-mode instance on shared inputs.
module tb_data_sync_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] unsync_bus;
  logic [3:0]  bus_enable;
  logic        out_ready;
  logic [3:0]  overrun_clr;

  logic [3:0] enable_pulse, overrun;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_chan;

  logic [3:0] t_enable_pulse, t_overrun;
  logic       t_out_valid;
  logic [7:0] t_out_data;
  logic [1:0] t_out_chan;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  data_sync_mc #(.NUM_STAGES(2), .DATA_WIDTH(8), .NUM_CH(4), .TOGGLE_MODE(0), .CHW(2)) dut (
    .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .enable_pulse(enable_pulse), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .overrun(overrun), .overrun_clr(overrun_clr));

  data_sync_mc #(.NUM_STAGES(2), .DATA_WIDTH(8), .NUM_CH(4), .TOGGLE_MODE(1), .CHW(2)) dut_t (
    .CLK(CLK), .RST(RST), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .enable_pulse(t_enable_pulse), .out_valid(t_out_valid), .out_ready(out_ready),
    .out_data(t_out_data), .out_chan(t_out_chan), .overrun(t_overrun), .overrun_clr(overrun_clr));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    RST = 1'b0; bus_enable = '0; unsync_bus = '0; out_ready = 1'b1; overrun_clr = '0;
    ticks(2);
    RST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    RST = 1'b0;
    #1;
    tests++; if ({out_valid, out_data, out_chan, enable_pulse, overrun} !== 19'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", {out_valid, out_data, out_chan, enable_pulse, overrun}); end
    tests++; if ({t_out_valid, t_out_data, t_out_chan, t_enable_pulse, t_overrun} !== 19'd0) begin
      fails++; $display("FAIL reset_outputs_toggle: got %h want 0", {t_out_valid, t_out_data, t_out_chan, t_enable_pulse, t_overrun}); end
    do_reset();
  endtask

  task automatic test_single();
    int pulses = 0;
    int words  = 0;
    do_reset();
    unsync_bus[16 +: 8] = 8'hA5;
    bus_enable[2] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (enable_pulse[2]) pulses++;
      if (out_valid) words++;
      if (c == 2) begin
        tests++; if (enable_pulse !== 4'b0000) begin fails++; $display("FAIL single_pulse_early: got %b want 0000", enable_pulse); end
      end
      if (c == 3) begin
        tests++; if (enable_pulse !== 4'b0100) begin fails++; $display("FAIL single_pulse: got %b want 0100", enable_pulse); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_valid_early: got %b want 0", out_valid); end
      end
      if (c == 4) begin
        tests++; if ({out_valid, out_data, out_chan} !== {1'b1, 8'hA5, 2'd2}) begin
          fails++; $display("FAIL single_word: got v=%b d=%h c=%0d want v=1 d=a5 c=2", out_valid, out_data, out_chan); end
      end
      if (c == 10) bus_enable[2] = 1'b0;
    end
    tests++; if (pulses !== 1) begin fails++; $display("FAIL single_pulse_count: got %0d want 1", pulses); end
    tests++; if (words !== 1) begin fails++; $display("FAIL single_word_count: got %0d want 1", words); end
  endtask

  task automatic test_toggle();
    logic [9:0] q[$];
    do_reset();
    unsync_bus[8 +: 8] = 8'h11;
    bus_enable[1] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) begin
        unsync_bus[8 +: 8] = 8'h22;
        bus_enable[1] = 1'b0;
      end
      tick();
      if (t_out_valid) q.push_back({t_out_chan, t_out_data});
    end
    tests++; if (q.size() !== 2) begin fails++; $display("FAIL toggle_count: got %0d want 2", q.size()); end
    if (q.size() == 2) begin
      tests++; if (q[0] !== {2'd1, 8'h11}) begin fails++; $display("FAIL toggle_word0: got %h want 111", q[0]); end
      tests++; if (q[1] !== {2'd1, 8'h22}) begin fails++; $display("FAIL toggle_word1: got %h want 122", q[1]); end
    end
    tests++; if (t_overrun !== 4'b0000) begin fails++; $display("FAIL toggle_overrun: got %b want 0000", t_overrun); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'h20; exp_seq[1] = 8'h30; exp_seq[2] = 8'h40;
    do_reset();
    out_ready = 1'b0;
    unsync_bus = 32'h40302010;
    bus_enable = 4'hF;
    ticks(4);
    tests++; if ({out_valid, out_data, out_chan} !== {1'b1, 8'h10, 2'd0}) begin
      fails++; $display("FAIL rr_first: got v=%b d=%h c=%0d want v=1 d=10 c=0", out_valid, out_data, out_chan); end
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if ({out_valid, out_data} !== {1'b1, 8'h10}) begin
        fails++; $display("FAIL rr_stall: got v=%b d=%h want v=1 d=10", out_valid, out_data); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++; if ({out_valid, out_data, out_chan} !== {1'b1, exp_seq[c], 2'(c + 1)}) begin
        fails++; $display("FAIL rr_order: got v=%b d=%h c=%0d want v=1 d=%h c=%0d", out_valid, out_data, out_chan, exp_seq[c], c + 1); end
    end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_drained: got %b want 0", out_valid); end
    tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL rr_overrun: got %b want 0000", overrun); end
    bus_enable = 4'h0;
  endtask

  task automatic fire_ch(input int ch, input logic [7:0] data);
    unsync_bus[ch*8 +: 8] = data;
    bus_enable[ch] = 1'b1;
    ticks(6);
    bus_enable[ch] = 1'b0;
    ticks(6);
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b0;
    fire_ch(3, 8'h55);
    fire_ch(3, 8'h66);
    fire_ch(3, 8'h77);
    tests++; if (overrun !== 4'b1000) begin fails++; $display("FAIL ovr_flag: got %b want 1000", overrun); end
    tests++; if ({out_valid, out_data, out_chan} !== {1'b1, 8'h55, 2'd3}) begin
      fails++; $display("FAIL ovr_head: got v=%b d=%h c=%0d want v=1 d=55 c=3", out_valid, out_data, out_chan); end
    out_ready = 1'b1;
    tick();
    tests++; if ({out_valid, out_data, out_chan} !== {1'b1, 8'h66, 2'd3}) begin
      fails++; $display("FAIL ovr_second: got v=%b d=%h c=%0d want v=1 d=66 c=3", out_valid, out_data, out_chan); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ovr_dropped: got valid %b want 0", out_valid); end
    tests++; if (overrun !== 4'b1000) begin fails++; $display("FAIL ovr_sticky: got %b want 1000", overrun); end
    overrun_clr[3] = 1'b1;
    tick();
    overrun_clr[3] = 1'b0;
    tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL ovr_clear: got %b want 0000", overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    fire_ch(0, 8'hA1);
    fire_ch(0, 8'hB2);
    unsync_bus[0 +: 8] = 8'hC3;
    bus_enable[0] = 1'b1;
    ticks(2);
    out_ready = 1'b1;
    tests++; if ({out_valid, out_data} !== {1'b1, 8'hA1}) begin
      fails++; $display("FAIL b2b_head: got v=%b d=%h want v=1 d=a1", out_valid, out_data); end
    tick();
    tests++; if ({out_valid, out_data, out_chan} !== {1'b1, 8'hB2, 2'd0}) begin
      fails++; $display("FAIL b2b_old: got v=%b d=%h c=%0d want v=1 d=b2 c=0", out_valid, out_data, out_chan); end
    tick();
    tests++; if ({out_valid, out_data, out_chan} !== {1'b1, 8'hC3, 2'd0}) begin
      fails++; $display("FAIL b2b_new: got v=%b d=%h c=%0d want v=1 d=c3 c=0", out_valid, out_data, out_chan); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
    tests++; if (overrun !== 4'b0000) begin fails++; $display("FAIL b2b_overrun: got %b want 0000", overrun); end
    bus_enable = 4'h0;
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    do_reset();
    out_ready = 1'b0;
    unsync_bus[0 +: 16] = 16'h0201;
    bus_enable[1:0] = 2'b11;
    ticks(5);
    tests++; if ({out_valid, out_data} !== {1'b1, 8'h01}) begin
      fails++; $display("FAIL mid_pre: got v=%b d=%h want v=1 d=01", out_valid, out_data); end
    #2;
    RST = 1'b0;
    bus_enable = 4'h0;
    #1;
    tests++; if ({out_valid, out_data, out_chan, enable_pulse, overrun} !== 19'd0) begin
      fails++; $display("FAIL mid_reset: got %h want 0", {out_valid, out_data, out_chan, enable_pulse, overrun}); end
    tick();
    RST = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) stale++;
    end
    tests++; if (stale !== 0) begin fails++; $display("FAIL mid_stale: got %0d words want 0", stale); end
    unsync_bus[0 +: 8] = 8'h9C;
    bus_enable[0] = 1'b1;
    ticks(4);
    tests++; if ({out_valid, out_data, out_chan} !== {1'b1, 8'h9C, 2'd0}) begin
      fails++; $display("FAIL mid_after: got v=%b d=%h c=%0d want v=1 d=9c c=0", out_valid, out_data, out_chan); end
    bus_enable = 4'h0;
  endtask

  initial begin
    RST = 1'b0; unsync_bus = '0; bus_enable = '0; out_ready = 1'b1; overrun_clr = '0;
    test_reset();
    test_single();
    test_toggle();
    test_round_robin();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
